ratio_test_multilane: RTL

Parametrised simplex ratio test: it picks the leaving (pivot) row. Each input beat carries NUM_LANES rows of right-hand-side (RHS) and pivot-column data. Per lane, the block divides RHS by the pivot-column element using single-precision divider cores, then reduces all lanes and all beats to the minimum non-negative ratio over eligible rows. It sits between the tableau column readout and the LP control FSM, reporting either continue (with the pivot row and its pivot-column element) or terminate (unbounded or arithmetic error).

---
 rtl/ratio_test_multilane.sv | 366 ++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ratio_test_multilane.sv
// ratio_test_multilane: simplex ratio test selecting the leaving (pivot) row.
//   Each beat carries NUM_LANES rows of RHS / pivot-column data. Every lane
//   divides RHS by its pivot-column element. A min-tree folds the lanes of a
//   result beat, and a running best folds the beats, giving the minimum
//   non-negative ratio over eligible rows. The lower row index wins ties.
// Latency: cont/terminate rise 2 cycles after the divider result of the last
//   beat (divider 2 cycles + reduction 1 + best update 1 after acceptance).
// Backpressure: in_ready is high only in RUN with every lane divider ready.
//   Divider results are never stalled.
// Ports: clk, reset (sync, active-high), start, num_rows,
//   in_valid/in_ready/in_rhs/in_pcol (beat input),
//   pivot_row_index, pivot_col_pivot_row_data, best_ratio, cont, terminate,
//   err_code (0 none, 1 unbounded, 2 division error).
// Build option: define PIVOT_ROW_EPS_EN to require pcol > EPS for eligibility.

// ratio_fp_div: IEEE754 single-precision divider core with AXI-like a/b inputs.
//   Latency is 2 cycles, and the core accepts a new operand pair every cycle.
//   Ready is low only while the core is held in reset. The result is not
//   back-pressured. Subnormal inputs are flushed to zero, and the quotient is
//   truncated toward zero.
// Ports: clk_i, reset_i, a_vld_i/a_dat_i/a_rdy_o, b_vld_i/b_dat_i/b_rdy_o,
//   res_vld_o/res_dat_o, res_user_o = {divbyzero, invalid, overflow, underflow}.
module ratio_fp_div (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        a_vld_i,
  input  logic [31:0] a_dat_i,
  output logic        a_rdy_o,
  input  logic        b_vld_i,
  input  logic [31:0] b_dat_i,
  output logic        b_rdy_o,
  output logic        res_vld_o,
  output logic [31:0] res_dat_o,
  output logic [3:0]  res_user_o
);
  logic        op_vld_q;
  logic [31:0] a_q, b_q;
  logic        res_vld_q;
  logic [31:0] res_q, res_d;
  logic [3:0]  user_q, user_d;

  logic        sign, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [47:0] num, den;
  logic [24:0] quo;
  logic [9:0]  exp_u;

  assign a_rdy_o = !reset_i;
  assign b_rdy_o = !reset_i;

  always_comb begin
    sign   = a_q[31] ^ b_q[31];
    a_nan  = (a_q[30:23] == 8'hff) && (a_q[22:0] != 23'd0);
    b_nan  = (b_q[30:23] == 8'hff) && (b_q[22:0] != 23'd0);
    a_inf  = (a_q[30:23] == 8'hff) && (a_q[22:0] == 23'd0);
    b_inf  = (b_q[30:23] == 8'hff) && (b_q[22:0] == 23'd0);
    a_zero = (a_q[30:23] == 8'h00);
    b_zero = (b_q[30:23] == 8'h00);
    num    = {1'b1, a_q[22:0], 24'd0};
    den    = {24'd0, 1'b1, b_q[22:0]};
    // Both mantissas lie in [1,2), so the quotient lies in [2^23, 2^25).
    quo    = 25'(num / den);
    // Negative results wrap and set bit 9. The positive range stays below 512.
    exp_u  = {2'b00, a_q[30:23]} + 10'd127 - {2'b00, b_q[30:23]} - {9'd0, ~quo[24]};
    res_d  = {sign, 31'd0};
    user_d = 4'd0;
    if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
      res_d  = 32'h7fc0_0000;
      user_d = 4'b0100;
    end else if (a_inf) begin
      res_d = {sign, 8'hff, 23'd0};
    end else if (b_zero) begin
      res_d  = {sign, 8'hff, 23'd0};
      user_d = 4'b1000;
    end else if (b_inf || a_zero) begin
      res_d = {sign, 31'd0};
    end else if (exp_u[9] || (exp_u == 10'd0)) begin
      res_d  = {sign, 31'd0};
      user_d = 4'b0001;
    end else if (exp_u >= 10'd255) begin
      res_d  = {sign, 8'hff, 23'd0};
      user_d = 4'b0010;
    end else begin
      res_d = {sign, exp_u[7:0], (quo[24] ? quo[23:1] : quo[22:0])};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      op_vld_q  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      res_vld_q <= 1'b0;
      res_q     <= '0;
      user_q    <= '0;
    end else begin
      op_vld_q  <= a_vld_i && b_vld_i;
      a_q       <= a_dat_i;
      b_q       <= b_dat_i;
      res_vld_q <= op_vld_q;
      res_q     <= res_d;
      user_q    <= user_d;
    end
  end

  assign res_vld_o  = res_vld_q;
  assign res_dat_o  = res_q;
  assign res_user_o = user_q;
endmodule

module ratio_test_multilane #(
  parameter int          DATAW      = 32,
  parameter int          NUM_ROWS_W = 16,
  parameter int          NUM_LANES  = 4,
  parameter logic [31:0] EPS        = 32'h3727_c5ac
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [NUM_ROWS_W-1:0]      num_rows,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_LANES*DATAW-1:0] in_rhs,
  input  logic [NUM_LANES*DATAW-1:0] in_pcol,
  output logic [NUM_ROWS_W-1:0]      pivot_row_index,
  output logic [DATAW-1:0]           pivot_col_pivot_row_data,
  output logic [DATAW-1:0]           best_ratio,
  output logic                       cont,
  output logic                       terminate,
  output logic [1:0]                 err_code
);
  localparam int RW = NUM_ROWS_W + 1;
  localparam logic [DATAW-1:0] POS_INF  = 32'h7f80_0000;
  localparam logic [DATAW-1:0] NEG_ZERO = 32'h8000_0000;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t state_q, state_d;

`ifdef PIVOT_ROW_EPS_EN
  function automatic logic pcol_ok(input logic [DATAW-1:0] p);
    logic nan;
    nan = (p[30:23] == 8'hff) && (p[22:0] != 23'd0);
    return !p[31] && (p[30:0] > EPS[30:0]) && !nan;
  endfunction
`else
  function automatic logic pcol_ok(input logic [DATAW-1:0] p);
    logic nan;
    nan = (p[30:23] == 8'hff) && (p[22:0] != 23'd0);
    return !p[31] && (p[30:0] != 31'd0) && !nan;
  endfunction
  logic unused_eps;
  assign unused_eps = ^EPS;
`endif

  // Pass control
  logic                  start_pass, busy, accept, last_beat;
  logic [NUM_ROWS_W-1:0] base_q, base_d, nrows_q, nrows_d;
  logic [NUM_LANES-1:0]  beat_elig;
  logic [RW-1:0]         lane_row;

  assign start_pass = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign accept     = in_valid && in_ready;
  assign last_beat  = ({1'b0, base_q} + RW'(NUM_LANES)) >= {1'b0, nrows_q};

  always_comb begin
    beat_elig = '0;
    lane_row  = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      lane_row = {1'b0, base_q} + RW'(k);
      beat_elig[k] = (lane_row < {1'b0, nrows_q})
                     && (!in_rhs[k*DATAW + DATAW-1] || (in_rhs[k*DATAW +: DATAW] == NEG_ZERO))
                     && pcol_ok(in_pcol[k*DATAW +: DATAW]);
    end
  end

  // Lane dividers. All lanes fire together, so they stay in lockstep.
  logic [NUM_LANES-1:0] a_rdy, b_rdy, res_vld;
  logic [DATAW-1:0]     res_dat  [NUM_LANES];
  logic [3:0]           res_user [NUM_LANES];
  logic                 res_vld_all;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    ratio_fp_div u_div (
      .clk_i      (clk),
      .reset_i    (reset),
      .a_vld_i    (accept),
      .a_dat_i    (in_rhs[k*DATAW +: DATAW]),
      .a_rdy_o    (a_rdy[k]),
      .b_vld_i    (accept),
      .b_dat_i    (in_pcol[k*DATAW +: DATAW]),
      .b_rdy_o    (b_rdy[k]),
      .res_vld_o  (res_vld[k]),
      .res_dat_o  (res_dat[k]),
      .res_user_o (res_user[k])
    );
  end
  assign res_vld_all = &res_vld;

  // Side-band pipeline matched to the divider latency. It carries the
  // eligibility, row base, pcol data and last-beat marker of each beat.
  logic [1:0][NUM_LANES-1:0]       elig_pipe_q;
  logic [1:0][NUM_ROWS_W-1:0]      base_pipe_q;
  logic [1:0][NUM_LANES*DATAW-1:0] pcol_pipe_q;
  logic [1:0]                      last_pipe_q;

  // Per-beat reduction. The scan runs from lane 0 with a strict less-than,
  // so the lowest row wins ties. Lanes with a flag are dropped from the min.
  logic                  red_found_d, red_err_d;
  logic [DATAW-1:0]      red_ratio_d, lane_ratio;
  logic [NUM_ROWS_W-1:0] red_row_d;
  logic [DATAW-1:0]      red_pcol_d;

  always_comb begin
    red_found_d = 1'b0;
    red_err_d   = 1'b0;
    red_ratio_d = '1;
    red_row_d   = '0;
    red_pcol_d  = '0;
    lane_ratio  = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      lane_ratio = (res_dat[k] == NEG_ZERO) ? '0 : res_dat[k];
      if (elig_pipe_q[1][k]) begin
        if (|res_user[k]) begin
          red_err_d = 1'b1;
        end else if (!red_found_d || (lane_ratio < red_ratio_d)) begin
          red_found_d = 1'b1;
          red_ratio_d = lane_ratio;
          red_row_d   = base_pipe_q[1] + NUM_ROWS_W'(k);
          red_pcol_d  = pcol_pipe_q[1][k*DATAW +: DATAW];
        end
      end
    end
  end

  logic                  red_vld_q, red_last_q, red_found_q, red_err_q;
  logic [DATAW-1:0]      red_ratio_q, red_pcol_q;
  logic [NUM_ROWS_W-1:0] red_row_q;

  // Running best and pass result
  logic [DATAW-1:0]      best_ratio_q, best_ratio_d, best_pcol_q, best_pcol_d;
  logic [NUM_ROWS_W-1:0] best_row_q, best_row_d;
  logic                  seen_q, seen_d, err_q, err_d;
  logic                  cont_q, cont_d, term_q, term_d;
  logic [1:0]            code_q, code_d;

  always_comb begin
    best_ratio_d = best_ratio_q;
    best_pcol_d  = best_pcol_q;
    best_row_d   = best_row_q;
    seen_d       = seen_q;
    err_d        = err_q;
    cont_d       = cont_q;
    term_d       = term_q;
    code_d       = code_q;
    base_d       = accept ? base_q + NUM_ROWS_W'(NUM_LANES) : base_q;
    nrows_d      = nrows_q;
    if (start_pass) begin
      best_ratio_d = POS_INF;
      best_pcol_d  = '0;
      best_row_d   = '0;
      seen_d       = 1'b0;
      err_d        = 1'b0;
      cont_d       = 1'b0;
      term_d       = 1'b0;
      code_d       = 2'd0;
      base_d       = '0;
      nrows_d      = num_rows;
    end else if (red_vld_q && busy) begin
      // Beats arrive in row order, so an equal ratio keeps the earlier row.
      if (red_found_q && (!seen_q || (red_ratio_q < best_ratio_q))) begin
        best_ratio_d = red_ratio_q;
        best_pcol_d  = red_pcol_q;
        best_row_d   = red_row_q;
      end
      seen_d = seen_q || red_found_q;
      err_d  = err_q || red_err_q;
      if (red_last_q) begin
        cont_d = !err_d && seen_d;
        term_d = err_d || !seen_d;
        code_d = err_d ? 2'd2 : (!seen_d ? 2'd1 : 2'd0);
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (accept && last_beat) state_d = S_DRAIN;
      S_DRAIN: if (red_vld_q && red_last_q) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready = (state_q == S_RUN) && (&a_rdy) && (&b_rdy);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q       <= '0;
      nrows_q      <= '0;
      elig_pipe_q  <= '0;
      base_pipe_q  <= '0;
      pcol_pipe_q  <= '0;
      last_pipe_q  <= '0;
      red_vld_q    <= 1'b0;
      red_last_q   <= 1'b0;
      red_found_q  <= 1'b0;
      red_err_q    <= 1'b0;
      red_ratio_q  <= '0;
      red_pcol_q   <= '0;
      red_row_q    <= '0;
      best_ratio_q <= POS_INF;
      best_pcol_q  <= '0;
      best_row_q   <= '0;
      seen_q       <= 1'b0;
      err_q        <= 1'b0;
      cont_q       <= 1'b0;
      term_q       <= 1'b0;
      code_q       <= 2'd0;
    end else begin
      base_q         <= base_d;
      nrows_q        <= nrows_d;
      elig_pipe_q[0] <= accept ? beat_elig : '0;
      elig_pipe_q[1] <= elig_pipe_q[0];
      base_pipe_q[0] <= base_q;
      base_pipe_q[1] <= base_pipe_q[0];
      pcol_pipe_q[0] <= in_pcol;
      pcol_pipe_q[1] <= pcol_pipe_q[0];
      last_pipe_q[0] <= accept && last_beat;
      last_pipe_q[1] <= last_pipe_q[0];
      red_vld_q      <= res_vld_all;
      red_last_q     <= res_vld_all && last_pipe_q[1];
      red_found_q    <= res_vld_all && red_found_d;
      red_err_q      <= res_vld_all && red_err_d;
      red_ratio_q    <= red_ratio_d;
      red_pcol_q     <= red_pcol_d;
      red_row_q      <= red_row_d;
      best_ratio_q   <= best_ratio_d;
      best_pcol_q    <= best_pcol_d;
      best_row_q     <= best_row_d;
      seen_q         <= seen_d;
      err_q          <= err_d;
      cont_q         <= cont_d;
      term_q         <= term_d;
      code_q         <= code_d;
    end
  end

  assign pivot_row_index          = best_row_q;
  assign pivot_col_pivot_row_data = best_pcol_q;
  assign best_ratio               = best_ratio_q;
  assign cont                     = cont_q;
  assign terminate                = term_q;
  assign err_code                 = code_q;
endmodule
